lbus_source_driver: RTL and testbench

Drives the L-bus from the source named by a 4-bit L-bus source selector code issued by the microsequencer each micro-step.
- Register-file, PC, IR and flag sources are latched with fixed 1-cycle latency.
- Main memory (MM) and I/O sources use a req/ack read handshake with a timeout.
- Sits between the register/memory/IO sources and the ALU L input; presents one registered, valid-qualified L-bus word per accepted request.

---
 rtl/lbus_source_driver.sv | 153 +++++++++++++++
 tb/tb_lbus_source_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lbus_source_driver.sv
// lbus_source_driver: selects one L-bus source per accepted request; register sources complete in one
// cycle, MM/IO sources complete through a req/ack read handshake bounded by a timeout.
module lbus_source_driver #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              sel,
    input  logic [8*DATA_WIDTH-1:0] gpr_flat,
    input  logic [DATA_WIDTH-1:0]   rb,
    input  logic [DATA_WIDTH-1:0]   rbp,
    input  logic [DATA_WIDTH-1:0]   pc,
    input  logic [DATA_WIDTH-1:0]   ir,
    input  logic [DATA_WIDTH-1:0]   fsr,
    output logic                    mm_rd_req,
    input  logic                    mm_rd_ack,
    input  logic [DATA_WIDTH-1:0]   mm_rd_data,
    output logic                    io_rd_req,
    input  logic                    io_rd_ack,
    input  logic [DATA_WIDTH-1:0]   io_rd_data,
    output logic [DATA_WIDTH-1:0]   lbus_data,
    output logic                    lbus_valid,
    output logic                    bus_error
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] SEL_RB  = 4'd8;
    localparam logic [3:0] SEL_RBP = 4'd9;
    localparam logic [3:0] SEL_PC  = 4'd10;
    localparam logic [3:0] SEL_IO  = 4'd11;
    localparam logic [3:0] SEL_MM  = 4'd12;
    localparam logic [3:0] SEL_IR  = 4'd13;
    localparam logic [3:0] SEL_FSR = 4'd14;

    typedef enum logic [1:0] {IDLE, WAIT_MM, WAIT_IO} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  mm_req_q, mm_req_d;
    logic                  io_req_q, io_req_d;
    logic [DATA_WIDTH-1:0] gpr [8];
    logic [DATA_WIDTH-1:0] src_word;
    logic                  wait_ack;
    logic [DATA_WIDTH-1:0] wait_data;

    always_comb begin
        for (int i = 0; i < 8; i++) gpr[i] = gpr_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // NLB (code 15) and the handshake codes fall through to zero
    always_comb begin
        src_word = '0;
        if (!sel[3]) src_word = gpr[sel[2:0]];
        else begin
            case (sel)
                SEL_RB:  src_word = rb;
                SEL_RBP: src_word = rbp;
                SEL_PC:  src_word = pc;
                SEL_IR:  src_word = ir;
                SEL_FSR: src_word = fsr;
                default: src_word = '0;
            endcase
        end
    end

    assign wait_ack  = (state_q == WAIT_MM) ? mm_rd_ack  : (state_q == WAIT_IO) ? io_rd_ack : 1'b0;
    assign wait_data = (state_q == WAIT_MM) ? mm_rd_data : io_rd_data;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        mm_req_d = mm_req_q;
        io_req_d = io_req_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (sel == SEL_MM) begin
                        state_d  = WAIT_MM;
                        mm_req_d = 1'b1;
                        cnt_d    = '0;
                    end else if (sel == SEL_IO) begin
                        state_d  = WAIT_IO;
                        io_req_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        data_d  = src_word;
                        valid_d = 1'b1;
                    end
                end
            end
            WAIT_MM, WAIT_IO: begin
                // ack takes priority over a timeout landing on the same cycle
                if (wait_ack) begin
                    data_d   = wait_data;
                    valid_d  = 1'b1;
                    mm_req_d = 1'b0;
                    io_req_d = 1'b0;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d   = '0;
                    valid_d  = 1'b1;
                    err_d    = 1'b1;
                    mm_req_d = 1'b0;
                    io_req_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                mm_req_d = 1'b0;
                io_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            mm_req_q <= 1'b0;
            io_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            mm_req_q <= mm_req_d;
            io_req_q <= io_req_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign lbus_data  = data_q;
    assign lbus_valid = valid_q;
    assign bus_error  = err_q;
    assign mm_rd_req  = mm_req_q;
    assign io_rd_req  = io_req_q;
endmodule

// File: tb/tb_lbus_source_driver.sv
// tb_lbus_source_driver: directed plus random stimulus checked each cycle against a transaction-level
// reference model of the L-bus source driver.
module tb_lbus_source_driver;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    sel = '0;
    logic [DW-1:0] gpr [8];
    logic [8*DW-1:0] gpr_flat;
    logic [DW-1:0] rb = '0, rbp = '0, pc = '0, ir = '0, fsr = '0;
    logic          mm_rd_req, io_rd_req;
    logic          mm_rd_ack = 1'b0, io_rd_ack = 1'b0;
    logic [DW-1:0] mm_rd_data = '0, io_rd_data = '0;
    logic [DW-1:0] lbus_data;
    logic          lbus_valid, bus_error;

    int n_assert = 0;
    int n_fail = 0;
    int m_wait = 0;
    int m_cnt = 0;
    logic [DW-1:0] m_data = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) gpr_flat[i*DW +: DW] = gpr[i];
    end

    lbus_source_driver #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .sel(sel),
        .gpr_flat(gpr_flat), .rb(rb), .rbp(rbp), .pc(pc), .ir(ir), .fsr(fsr),
        .mm_rd_req(mm_rd_req), .mm_rd_ack(mm_rd_ack), .mm_rd_data(mm_rd_data),
        .io_rd_req(io_rd_req), .io_rd_ack(io_rd_ack), .io_rd_data(io_rd_data),
        .lbus_data(lbus_data), .lbus_valid(lbus_valid), .bus_error(bus_error)
    );

    function automatic logic [DW-1:0] src(input logic [3:0] s);
        if (s < 8) return gpr[s[2:0]];
        if (s == 8) return rb;
        if (s == 9) return rbp;
        if (s == 10) return pc;
        if (s == 13) return ir;
        if (s == 14) return fsr;
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rnd_src();
        for (int i = 0; i < 8; i++) gpr[i] = DW'($urandom);
        rb = DW'($urandom); rbp = DW'($urandom); pc = DW'($urandom);
        ir = DW'($urandom); fsr = DW'($urandom);
    endtask

    // m_wait: 0 no read outstanding, 1 memory read, 2 IO read; m_cnt counts cycles already waited
    task automatic cycle();
        logic          v = 1'b0;
        logic          e = 1'b0;
        logic [DW-1:0] d = m_data;
        int            w = m_wait;
        int            c = m_cnt;
        if (w == 0) begin
            if (req_valid) begin
                if (sel == 12) begin w = 1; c = 0; end
                else if (sel == 11) begin w = 2; c = 0; end
                else begin d = src(sel); v = 1'b1; end
            end
        end else if ((w == 1 && mm_rd_ack) || (w == 2 && io_rd_ack)) begin
            d = (w == 1) ? mm_rd_data : io_rd_data;
            v = 1'b1;
            w = 0;
        end else if (c + 1 == TO) begin
            d = '0; v = 1'b1; e = 1'b1; w = 0;
        end else begin
            c++;
        end
        @(posedge clk);
        #1;
        chk("lbus_valid", DW'(lbus_valid), DW'(v));
        chk("bus_error", DW'(bus_error), DW'(e));
        chk("lbus_data", lbus_data, d);
        chk("mm_rd_req", DW'(mm_rd_req), DW'(w == 1));
        chk("io_rd_req", DW'(io_rd_req), DW'(w == 2));
        chk("req_ready", DW'(req_ready), DW'(w == 0));
        m_wait = w;
        m_cnt = c;
        m_data = d;
    endtask

    initial begin
        rnd_src();
        #1;
        chk("rst_ready", DW'(req_ready), DW'(1));
        chk("rst_valid", DW'(lbus_valid), '0);
        chk("rst_data", lbus_data, '0);
        chk("rst_mm_req", DW'(mm_rd_req), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // register, PC and NLB sources back to back
        gpr[3] = 16'h1234; pc = 16'hBEEF;
        req_valid = 1'b1; sel = 4'd3;
        cycle();
        chk("t2_r3", lbus_data, 16'h1234);
        sel = 4'd10;
        cycle();
        chk("t2_pc", lbus_data, 16'hBEEF);
        sel = 4'd15;
        cycle();
        chk("t2_nlb", lbus_data, 16'h0000);
        chk("t2_nlb_valid", DW'(lbus_valid), DW'(1));
        for (int s = 0; s < 16; s++) begin
            if (s != 11 && s != 12) begin
                sel = 4'(s);
                cycle();
            end
        end

        // memory read acked on the third wait cycle, requests during the wait ignored
        sel = 4'd12; mm_rd_data = 16'hA5A5;
        cycle();
        sel = 4'd3;
        cycle();
        cycle();
        req_valid = 1'b0; mm_rd_ack = 1'b1;
        cycle();
        mm_rd_ack = 1'b0;
        chk("t3_data", lbus_data, 16'hA5A5);
        chk("t3_err", DW'(bus_error), '0);
        cycle();
        chk("t3_hold", lbus_data, 16'hA5A5);

        // IO timeout, then stray IO acks while idle
        req_valid = 1'b1; sel = 4'd11; io_rd_data = 16'h7777;
        cycle();
        req_valid = 1'b0;
        repeat (TO) cycle();
        chk("t4_err", DW'(bus_error), DW'(1));
        chk("t4_data", lbus_data, '0);
        io_rd_ack = 1'b1;
        repeat (2) cycle();
        io_rd_ack = 1'b0;

        // ack collides with the timeout cycle
        req_valid = 1'b1; sel = 4'd12; mm_rd_data = 16'h0F0F;
        cycle();
        req_valid = 1'b0;
        repeat (TO - 1) cycle();
        mm_rd_ack = 1'b1;
        cycle();
        mm_rd_ack = 1'b0;
        chk("t5_data", lbus_data, 16'h0F0F);
        chk("t5_err", DW'(bus_error), '0);

        // cross ack: IO ack in a memory wait is ignored
        req_valid = 1'b1; sel = 4'd12;
        cycle();
        req_valid = 1'b0; io_rd_ack = 1'b1; io_rd_data = 16'hFFFF;
        cycle();
        chk("t6_no_valid", DW'(lbus_valid), '0);
        io_rd_ack = 1'b0; mm_rd_ack = 1'b1; mm_rd_data = 16'h0001;
        cycle();
        mm_rd_ack = 1'b0;
        chk("t6_data", lbus_data, 16'h0001);
        cycle();

        for (int k = 0; k < 600; k++) begin
            if (k % 16 == 0) rnd_src();
            req_valid = ($urandom_range(0, 3) != 0);
            sel = 4'($urandom_range(0, 15));
            mm_rd_ack = ($urandom_range(0, 4) == 0);
            io_rd_ack = ($urandom_range(0, 4) == 0);
            mm_rd_data = DW'($urandom);
            io_rd_data = DW'($urandom);
            cycle();
        end

        // asynchronous reset in the middle of a memory wait
        req_valid = 1'b0; mm_rd_ack = 1'b0; io_rd_ack = 1'b0;
        repeat (TO + 1) cycle();
        gpr[3] = 16'h5A5A; req_valid = 1'b1; sel = 4'd3;
        cycle();
        sel = 4'd12;
        cycle();
        req_valid = 1'b0;
        cycle();
        chk("t1_mm_req_pre", DW'(mm_rd_req), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_mm_req", DW'(mm_rd_req), '0);
        chk("t1_valid", DW'(lbus_valid), '0);
        chk("t1_data", lbus_data, '0);
        chk("t1_ready", DW'(req_ready), DW'(1));
        m_wait = 0; m_cnt = 0; m_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
